// File: rtl/b01_serial_adder_mc_if.sv
// rtl/b01_serial_adder_mc_if.sv - beat/result bundle for the multi-lane serial adder
interface b01_serial_adder_mc_if #(
  parameter int LANES = 2
);
  logic             valid_in;
  logic             sof;
  logic             mode;
  logic [LANES-1:0] line1;
  logic [LANES-1:0] line2;
  logic [LANES-1:0] outp;
  logic [LANES-1:0] overflw;
  logic             frame_done;
  logic             busy;

  modport master (
    output valid_in, sof, mode, line1, line2,
    input  outp, overflw, frame_done, busy
  );

  modport slave (
    input  valid_in, sof, mode, line1, line2,
    output outp, overflw, frame_done, busy
  );
endinterface

// File: rtl/b01_serial_adder_mc.sv
// rtl/b01_serial_adder_mc.sv - multi-lane LSB-first serial add/subtract with frame sync
module b01_serial_adder_mc #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  b01_serial_adder_mc_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [LANES-1:0] carry, carry_n;
  logic [LANES-1:0] outp_q, outp_n;
  logic [LANES-1:0] ovf_q, ovf_n;
  logic             mode_q, mode_n;
  logic             done_q, done_n;

  logic             op;
  logic [LANES-1:0] cin, beff, sum, cout;

  // Subtract is A + ~B + 1: invert B and seed the carry with the mode bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    carry_n = carry;
    outp_n  = outp_q;
    ovf_n   = ovf_q;
    mode_n  = mode_q;
    done_n  = 1'b0;

    op   = bus.sof ? bus.mode : mode_q;
    cin  = bus.sof ? {LANES{bus.mode}} : carry;
    beff = bus.line2 ^ {LANES{op}};
    sum  = bus.line1 ^ beff ^ cin;
    cout = (bus.line1 & beff) | (bus.line1 & cin) | (beff & cin);

    if (bus.valid_in && (bus.sof || state == RUN)) begin
      outp_n  = sum;
      carry_n = cout;
      mode_n  = op;
      if (bus.sof) begin
        ovf_n = '0;
      end
      if ((bus.sof && WIDTH == 1) || (!bus.sof && cnt == LAST)) begin
        ovf_n   = cout ^ {LANES{op}};
        done_n  = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        cnt_n   = bus.sof ? CW'(1) : cnt + CW'(1);
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= '0;
      outp_q <= '0;
      ovf_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      carry  <= carry_n;
      outp_q <= outp_n;
      ovf_q  <= ovf_n;
      mode_q <= mode_n;
      done_q <= done_n;
    end
  end

  assign bus.outp       = outp_q;
  assign bus.overflw    = ovf_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = (state == RUN);
endmodule

// File: tb/tb_b01_serial_adder_mc.sv
// tb/tb_b01_serial_adder_mc.sv - scoreboard bench for the multi-lane serial adder
module tb_b01_serial_adder_mc;
  localparam int LANES = 2;
  localparam int WIDTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  b01_serial_adder_mc_if #(.LANES(LANES)) bus0 ();
  b01_serial_adder_mc_if #(.LANES(LANES)) bus1 ();

  b01_serial_adder_mc #(.LANES(LANES), .WIDTH(WIDTH)) u0 (.clock(clock), .reset(reset), .bus(bus0));
  b01_serial_adder_mc #(.LANES(LANES), .WIDTH(1))     u1 (.clock(clock), .reset(reset), .bus(bus1));

  typedef struct {
    logic [15:0] word;
    logic [1:0]  ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: whole-word unsigned arithmetic per lane.
  function automatic exp_t model(input logic [7:0] a0, b0, a1, b1, input logic m);
    exp_t r;
    int   s0, s1;
    if (m) begin
      s0   = int'(a0) - int'(b0);
      s1   = int'(a1) - int'(b1);
      r.ov = {a1 < b1, a0 < b0};
    end else begin
      s0   = int'(a0) + int'(b0);
      s1   = int'(a1) + int'(b1);
      r.ov = {s1 > 255, s0 > 255};
    end
    r.word = {s1[7:0], s0[7:0]};
    return r;
  endfunction

  task automatic drive0(input logic v, s, m, input logic [1:0] l1, l2);
    bus0.valid_in = v;
    bus0.sof      = s;
    bus0.mode     = m;
    bus0.line1    = l1;
    bus0.line2    = l2;
  endtask

  task automatic drive1(input logic v, s, m, input logic [1:0] l1, l2);
    bus1.valid_in = v;
    bus1.sof      = s;
    bus1.mode     = m;
    bus1.line1    = l1;
    bus1.line2    = l2;
  endtask

  task automatic stall_beat();
    drive0(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] a0, b0, a1, b1, input logic m,
                            input int stall_pct, input int abort_at,
                            input int stall_at, input int stall_len);
    logic [1:0] snap;
    if (abort_at < 0) exp_q.push_back(model(a0, b0, a1, b1, m));
    for (int k = 0; k < WIDTH; k++) begin
      if (k == abort_at) return;
      @(negedge clock);
      if (k == 1) begin
        chk("overflw_cleared_by_sof", 32'(bus0.overflw), 32'(0));
        chk("busy_in_frame", 32'(bus0.busy), 32'(1));
      end
      if (k == stall_at) begin
        snap = bus0.outp;
        for (int j = 0; j < stall_len; j++) begin
          stall_beat();
          @(negedge clock);
          chk("stall_outp_frozen", 32'(bus0.outp), 32'(snap));
          chk("stall_busy", 32'(bus0.busy), 32'(1));
          chk("stall_no_done", 32'(bus0.frame_done), 32'(0));
        end
      end
      while (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
        stall_beat();
        @(negedge clock);
      end
      drive0(1'b1, k == 0, (k == 0) ? m : 1'($urandom_range(0, 1)),
             {a1[k], a0[k]}, {b1[k], b0[k]});
    end
  endtask

  task automatic idle_hold(input logic [1:0] ov_exp);
    logic [1:0] snap;
    @(negedge clock);
    chk("frame_done_pulse", 32'(bus0.frame_done), 32'(1));
    chk("busy_after_frame", 32'(bus0.busy), 32'(0));
    snap = bus0.outp;
    drive0(1'b1, 1'b0, 1'b0, 2'($urandom), 2'($urandom));
    repeat (3) begin
      @(negedge clock);
      chk("idle_outp_hold", 32'(bus0.outp), 32'(snap));
      chk("idle_overflw_hold", 32'(bus0.overflw), 32'(ov_exp));
      chk("idle_busy", 32'(bus0.busy), 32'(0));
      chk("idle_no_done", 32'(bus0.frame_done), 32'(0));
      drive0(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom));
    end
  endtask

  // Monitor: assemble serial result per lane and score each completed frame.
  logic       mon_v, mon_s;
  logic [7:0] acc0, acc1;
  int         beats = 0;
  exp_t       e;
  always @(posedge clock) begin
    mon_v = bus0.valid_in;
    mon_s = bus0.sof;
    #1;
    if (!reset) begin
      if (mon_v) begin
        beats = mon_s ? 1 : beats + 1;
        acc0  = {bus0.outp[0], acc0[7:1]};
        acc1  = {bus0.outp[1], acc1[7:1]};
      end
      if (bus0.frame_done) begin
        if (exp_q.size() == 0) begin
          chk("frame_done_with_empty_queue", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          chk("result_word", 32'({acc1, acc0}), 32'(e.word));
          chk("result_overflw", 32'(bus0.overflw), 32'(e.ov));
          chk("frame_beats", 32'(beats), 32'(WIDTH));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    drive0(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    drive1(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clock);
    @(negedge clock);
    chk("reset_outp", 32'(bus0.outp), 32'(0));
    chk("reset_overflw", 32'(bus0.overflw), 32'(0));
    chk("reset_frame_done", 32'(bus0.frame_done), 32'(0));
    chk("reset_busy", 32'(bus0.busy), 32'(0));
    chk("reset_w1_busy", 32'(bus1.busy), 32'(0));
    reset = 1'b0;

    // Directed add, subtract, stall and resync-abort frames.
    send_frame(8'h35, 8'h4A, 8'hFF, 8'h01, 1'b0, 0, -1, -1, 0);
    idle_hold(2'b10);
    send_frame(8'h10, 8'h20, 8'h20, 8'h10, 1'b1, 0, -1, -1, 0);
    idle_hold(2'b01);
    send_frame(8'h35, 8'h4A, 8'hFF, 8'h01, 1'b0, 0, -1, 4, 3);
    idle_hold(2'b10);
    send_frame(8'h35, 8'h4A, 8'hFF, 8'h01, 1'b0, 0, 5, -1, 0);
    send_frame(8'h01, 8'h01, 8'h80, 8'h80, 1'b0, 0, -1, -1, 0);
    idle_hold(2'b10);

    // Asynchronous reset in the middle of a frame.
    send_frame(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 0, 5, -1, 0);
    @(posedge clock);
    #1;
    chk("pre_reset_outp", 32'(bus0.outp), 32'(2'b11));
    #1 reset = 1'b1;
    #1;
    chk("async_reset_outp", 32'(bus0.outp), 32'(0));
    chk("async_reset_overflw", 32'(bus0.overflw), 32'(0));
    chk("async_reset_busy", 32'(bus0.busy), 32'(0));
    chk("async_reset_done", 32'(bus0.frame_done), 32'(0));
    @(negedge clock);
    drive0(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("post_reset_ignored_busy", 32'(bus0.busy), 32'(0));
      chk("post_reset_ignored_outp", 32'(bus0.outp), 32'(0));
      drive0(1'b1, 1'b0, 1'b0, 2'b11, 2'b01);
    end
    send_frame(8'hA5, 8'h5A, 8'h00, 8'h01, 1'b1, 0, -1, -1, 0);

    // Randomized frames with stalls, gaps and resync aborts.
    for (int n = 0; n < 30; n++) begin
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 20,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, WIDTH - 1)) : -1,
                 -1, 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        stall_beat();
      end
    end
    @(negedge clock);
    drive0(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // WIDTH=1: every sof beat is also the final beat.
    @(negedge clock);
    drive1(1'b1, 1'b1, 1'b0, 2'b11, 2'b11);
    @(negedge clock);
    chk("w1_add_outp", 32'(bus1.outp), 32'(2'b00));
    chk("w1_add_overflw", 32'(bus1.overflw), 32'(2'b11));
    chk("w1_add_done", 32'(bus1.frame_done), 32'(1));
    chk("w1_add_busy", 32'(bus1.busy), 32'(0));
    drive1(1'b1, 1'b1, 1'b1, 2'b01, 2'b11);
    @(negedge clock);
    chk("w1_sub_outp", 32'(bus1.outp), 32'(2'b10));
    chk("w1_sub_overflw", 32'(bus1.overflw), 32'(2'b10));
    chk("w1_sub_done", 32'(bus1.frame_done), 32'(1));
    chk("w1_sub_busy", 32'(bus1.busy), 32'(0));
    drive1(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    @(negedge clock);
    chk("w1_idle_outp", 32'(bus1.outp), 32'(2'b10));
    chk("w1_idle_overflw", 32'(bus1.overflw), 32'(2'b10));
    chk("w1_idle_done", 32'(bus1.frame_done), 32'(0));
    drive1(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    repeat (3) @(negedge clock);
    chk("all_frames_seen", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
